// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and status bundle for uart_rx.
// The receiver is the master: it drives data, valid and flags; the consumer drives ready.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   modport master (output rx_data, rx_valid, rx_busy, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, rx_busy, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled start check, mid-bit sampling, and a
// one-deep output register with valid/ready, framing-error and overrun pulses.
module uart_rx #(
   parameter int CLK_PER_BIT = 434
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam logic [13:0] HALF_M1 = 14'(CLK_PER_BIT / 2 - 1);
   localparam logic [13:0] BIT_M1  = 14'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t      state, state_n;
   logic        sync1, rx_s;
   logic [13:0] clk_count, cnt_n;
   logic [2:0]  bit_index, idx_n;
   logic [7:0]  rx_shift, shift_n;
   logic [7:0]  rx_data;
   logic        rx_valid, frame_err, overrun;
   logic        load, ferr;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = clk_count;
      idx_n   = bit_index;
      shift_n = rx_shift;
      load    = 1'b0;
      ferr    = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (clk_count == HALF_M1) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = clk_count + 14'd1;
            end
         end
         DATA: begin
            if (clk_count == BIT_M1) begin
               cnt_n              = '0;
               shift_n[bit_index] = rx_s;
               idx_n              = bit_index + 3'd1;
               if (bit_index == 3'd7) state_n = STOP;
            end else begin
               cnt_n = clk_count + 14'd1;
            end
         end
         STOP: begin
            if (clk_count == BIT_M1) begin
               cnt_n = '0;
               if (rx_s) begin
                  load    = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end else begin
               cnt_n = clk_count + 14'd1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         clk_count <= '0;
         bit_index <= '0;
         rx_shift  <= '0;
      end else begin
         state     <= state_n;
         clk_count <= cnt_n;
         bit_index <= idx_n;
         rx_shift  <= shift_n;
      end
   end

   // A new byte always wins; overrun only when the old byte was not taken this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= load && rx_valid && !bus.rx_ready;
         if (load) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (rx_valid && bus.rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.rx_busy   = (state != IDLE);
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed timing sequences, a vector
// table, randomized frames against a queue model, and a 256-byte transmitter loopback.
module tb_uart_rx;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   uart_rx_if bus();

   uart_rx #(.CLK_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Monitor at negedge: outputs are settled, and valid&&ready here means a
   // handshake on the coming rising edge.
   logic [7:0] got[$];
   int ferr_cnt = 0;
   int ovr_cnt  = 0;
   int busy_cnt = 0;
   always @(negedge clk) begin
      if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun)   ovr_cnt++;
      if (bus.rx_busy)   busy_cnt++;
   end

   int total = 0;
   int bad   = 0;
   int gi    = 0;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic [7:0] d;
      logic       v;
      int         f;
   } vec_t;
   vec_t vt[7];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic check_got(input string nm, input int exp);
      int act;
      if (gi < got.size()) begin
         act = got[gi];
         gi++;
      end else begin
         act = -1;
      end
      chk(nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_data"},  bus.rx_data,   0);
      chk({nm, "_valid"}, bus.rx_valid,  0);
      chk({nm, "_busy"},  bus.rx_busy,   0);
      chk({nm, "_ferr"},  bus.frame_err, 0);
      chk({nm, "_ovr"},   bus.overrun,   0);
   endtask

   task automatic drain();
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
   endtask

   // Behavioural transmitter: 10 bits of CPB cycles each, called just after a clock edge.
   // tchk checks the rx_valid rise edge; rpulse raises ready only on the stop-sample
   // cycle; abort_t (>=0) resets the DUT at that cycle offset into the frame.
   task automatic send_frame(input logic [7:0] b, input logic sb, input bit tchk,
                             input bit rpulse, input int abort_t);
      int t;
      for (int i = 0; i < 10; i++) begin
         rx = (i == 0) ? 1'b0 : (i == 9) ? sb : b[i-1];
         for (int j = 0; j < CPB; j++) begin
            t = CPB * i + j;
            // T0 = start drive + 3 edges; stop sample at T0 + 8 + 9*16.
            if (tchk && t == 154) chk("a5_valid_before", bus.rx_valid, 0);
            if (tchk && t == 155) chk("a5_valid_rise", bus.rx_valid, 1);
            if (rpulse && t == 154) bus.rx_ready = 1'b1;
            if (rpulse && t == 155) bus.rx_ready = 1'b0;
            if (t == abort_t) begin
               rst_n = 1'b0;
               #2;
               chk_reset_outs("midreset");
               rx = 1'b1;
               tick(); tick(); tick();
               rst_n = 1'b1;
               return;
            end
            tick();
         end
      end
   endtask

   initial begin
      int f0, o0, nbad, gap;
      logic [7:0] rb;
      bit good;
      int exp_q[$];

      vt[0] = '{b:8'hA5, stop:1'b1, d:8'hA5, v:1'b1, f:0};
      vt[1] = '{b:8'h3C, stop:1'b0, d:8'hA5, v:1'b0, f:1};
      vt[2] = '{b:8'h01, stop:1'b1, d:8'h01, v:1'b1, f:0};
      vt[3] = '{b:8'hFF, stop:1'b1, d:8'hFF, v:1'b1, f:0};
      vt[4] = '{b:8'h80, stop:1'b0, d:8'hFF, v:1'b0, f:1};
      vt[5] = '{b:8'h00, stop:1'b1, d:8'h00, v:1'b1, f:0};
      vt[6] = '{b:8'h7E, stop:1'b1, d:8'h7E, v:1'b1, f:0};

      rst_n = 1'b0;
      rx = 1'b1;
      bus.rx_ready = 1'b0;
      tick(); tick(); tick();
      chk_reset_outs("reset");
      rst_n = 1'b1;
      repeat (5) tick();

      // Single frame with exact rise timing, then a one-cycle ready.
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
      chk("a5_data", bus.rx_data, 8'hA5);
      chk("a5_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      chk("a5_valid_drop", bus.rx_valid, 0);
      repeat (10) tick();

      // Glitch: busy for exactly HALF cycles, nothing reported.
      f0 = ferr_cnt; gap = busy_cnt;
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      repeat (30) tick();
      chk("glitch_busy_cycles", busy_cnt - gap, CPB / 2);
      chk("glitch_valid", bus.rx_valid, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);

      // Bad stop, line held low, then recovery.
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      repeat (40) tick();
      chk("ferr_pulses", ferr_cnt - f0, 1);
      chk("ferr_valid", bus.rx_valid, 0);
      chk("ferr_busy_low_line", bus.rx_busy, 1);
      rx = 1'b1;
      tick(); tick();
      chk("ferr_busy_wait", bus.rx_busy, 1);
      tick(); tick();
      chk("ferr_busy_release", bus.rx_busy, 0);
      repeat (10) tick();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
      chk("ferr_next_data", bus.rx_data, 8'h01);
      chk("ferr_next_valid", bus.rx_valid, 1);

      // Vector table.
      for (int k = 0; k < 7; k++) begin
         drain();
         f0 = ferr_cnt;
         send_frame(vt[k].b, vt[k].stop, 1'b0, 1'b0, -1);
         rx = 1'b1;
         repeat (24) tick();
         chk($sformatf("vec%0d_data", k), bus.rx_data, vt[k].d);
         chk($sformatf("vec%0d_valid", k), bus.rx_valid, vt[k].v);
         chk($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vt[k].f);
      end

      // Back-to-back, never ready: overwrite plus one overrun.
      drain();
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
      repeat (10) tick();
      chk("b2b_ovr", ovr_cnt - o0, 1);
      chk("b2b_data", bus.rx_data, 8'h22);
      chk("b2b_valid", bus.rx_valid, 1);

      // Back-to-back, ready only on the second stop-sample cycle.
      drain();
      repeat (5) tick();
      o0 = ovr_cnt;
      gi = got.size();
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1, -1);
      repeat (10) tick();
      chk("b2b_rdy_ovr", ovr_cnt - o0, 0);
      chk("b2b_rdy_data", bus.rx_data, 8'h22);
      chk("b2b_rdy_valid", bus.rx_valid, 1);
      check_got("b2b_rdy_consumed", 8'h11);

      // Random frames against a queue model: good stops deliver in order, bad ones count.
      drain();
      repeat (5) tick();
      bus.rx_ready = 1'b1;
      gi = got.size();
      f0 = ferr_cnt; o0 = ovr_cnt; nbad = 0;
      for (int k = 0; k < 30; k++) begin
         rb = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 3) != 0);
         send_frame(rb, good, 1'b0, 1'b0, -1);
         if (good) exp_q.push_back(int'(rb));
         else nbad++;
         rx = 1'b1;
         gap = good ? $urandom_range(0, 8) : 16 + $urandom_range(0, 8);
         repeat (gap) tick();
      end
      repeat (30) tick();
      foreach (exp_q[k]) check_got($sformatf("rand_byte%0d", k), exp_q[k]);
      chk("rand_count", got.size() - gi, 0);
      chk("rand_ferr", ferr_cnt - f0, nbad);
      chk("rand_ovr", ovr_cnt - o0, 0);

      // Loopback of every byte value, back-to-back with one stop bit.
      gi = got.size();
      f0 = ferr_cnt; o0 = ovr_cnt;
      for (int k = 0; k < 256; k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0, -1);
      repeat (20) tick();
      for (int k = 0; k < 256; k++) check_got($sformatf("loop_%0d", k), k);
      chk("loop_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

      // Reset during data bit 4 with a byte pending, then a clean frame.
      bus.rx_ready = 1'b0;
      send_frame(8'h33, 1'b1, 1'b0, 1'b0, -1);
      tick();
      chk("pre_reset_valid", bus.rx_valid, 1);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, CPB * 5 + 8);
      repeat (20) tick();
      f0 = ferr_cnt;
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
      repeat (5) tick();
      chk("post_reset_data", bus.rx_data, 8'h5A);
      chk("post_reset_valid", bus.rx_valid, 1);
      chk("post_reset_ferr", ferr_cnt - f0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that pairs with the team's `uart_tx` on the far end of the line. It oversamples the asynchronous `rx` pin at the system clock, validates the start bit, and samples 8 data bits (LSB first) plus one stop bit at bit centres. It presents each good byte in a one-deep holding register with a valid/ready handshake, and flags framing errors and overruns. It is the receive half of the UART pair and uses the same frame format and bit-timing parameter as the transmitter.

## Interface
- `CLK_PER_BIT`, default 434: clocks per bit (115200 baud at 50 MHz); legal range 4..16383.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last good received byte.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rx_busy`  output  1  high while a frame is in progress (state != IDLE).
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: good byte arrived while previous one unconsumed.

## Operation
- Synchronizer: two flops on `rx`, both reset to 1. The output `rx_s` is the only copy of the line used internally.
- Counters:
  - `clk_count` is 14 bits, reset 0.
  - `bit_index` is 3 bits, reset 0.
  - `HALF` = `CLK_PER_BIT/2` (integer division).
- States: IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE.
- IDLE: when `rx_s==0`, go to START with `clk_count<=0`.
- START:
  - Increment `clk_count` until it equals `HALF-1`.
  - On that cycle sample `rx_s`.
  - If 0: go to DATA, with `clk_count<=0` and `bit_index<=0`.
  - If 1: treat as a glitch and return to IDLE. No flag is raised.
- DATA:
  - Increment `clk_count` until it equals `CLK_PER_BIT-1`.
  - On that cycle: `clk_count<=0`, shift `rx_s` into `rx_shift[bit_index]`, and increment `bit_index`.
  - After `bit_index==7` is sampled, go to STOP.
- STOP: count to `CLK_PER_BIT-1`, then sample:
  - `rx_s==1`: load `rx_data<=rx_shift`, set `rx_valid<=1`, go to IDLE.
  - `rx_s==0`: pulse `frame_err`. `rx_data` and `rx_valid` are untouched. Go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This prevents a break or stuck-low line from retriggering frames.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`.
  - A good-stop load while `rx_valid==1` and `rx_ready==0`:
    - `rx_data` is overwritten with the new byte and `rx_valid` stays 1.
    - `overrun` pulses.
  - Load and consume on the same cycle: the new byte is loaded, `rx_valid` stays 1, and there is no overrun.
- `rx_ready` is ignored while `rx_valid==0`.

## Timing
- Reset values:
  - `rx_data=8'h00`, `rx_valid=0`, `rx_busy=0`, `frame_err=0`, `overrun=0`.
  - State is IDLE.
  - Both synchronizer flops are 1.
- Let T0 be the first edge at which `rx_s==0` in IDLE. The synchronizer adds 2 cycles after the pin falls.
- Start check occurs at edge T0+`HALF`.
- Data bit k (k=0..7) is sampled at edge T0+`HALF`+(k+1)·`CLK_PER_BIT`.
- Stop bit is sampled at edge T0+`HALF`+9·`CLK_PER_BIT`. `rx_valid`, `frame_err` and `overrun` are registered on that edge.
- `rx_busy` goes high the cycle after T0 and low on the stop-sample edge (good stop) or when WAIT_IDLE exits.
- Back-to-back frames: a next start edge arriving `CLK_PER_BIT-HALF` cycles after the stop sample (a nominal 1 stop bit from `uart_tx`) is detected with no lost frame.
- Reset mid-frame:
  - All state returns to reset values immediately, including a pending `rx_valid`.
  - After reset, a line already low enters START. If it stays low it gives one framing error and then WAIT_IDLE.

## Test plan
Bench runs with `CLK_PER_BIT=16`.

- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) with `rx_ready=0`: `rx_valid` rises at T0+8+144, `rx_data=8'hA5`, no flags. Then `rx_ready=1` for 1 cycle: `rx_valid` drops next cycle.
- Glitch: `rx` low for 4 cycles then high: returns to IDLE after the start check, `rx_busy` high only that window, no `rx_valid` and no `frame_err`.
- Frame 0x3C with stop bit driven low, then line held low 40 cycles: one `frame_err` pulse, `rx_valid` stays 0, `rx_busy` high until `rx_s` returns to 1, next frame 0x01 received correctly.
- Back-to-back frames 0x11 then 0x22, `rx_ready=0` throughout:
  - `overrun` pulses once on the second stop sample.
  - `rx_data=8'h22`, `rx_valid=1`.
- Back-to-back frames with `rx_ready` high exactly on the second stop-sample cycle: `rx_data=8'h22`, `rx_valid=1`, no `overrun`.
- Loopback to `uart_tx` (same `CLK_PER_BIT`), 256 sequential bytes 0x00..0xFF with `rx_ready=1`: every byte matches in order, zero flags.
- `rst_n` pulsed low mid-DATA on bit 4: all outputs return to reset values asynchronously; the following frame 0x5A is received intact.
